// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-in/parallel-out receiver with valid/ready handshake and sticky overrun
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rest_n,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             shifter,
  input  logic             sync,
  input  logic             data_ready,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             eff_dir;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // The first bit of a word already follows the freshly sampled direction.
  always_comb begin
    eff_dir = (state_q == IDLE) ? shifter : dir_q;
    shifted = eff_dir ? {serial_in, shift_q[WIDTH-1:1]}
                      : {shift_q[WIDTH-2:0], serial_in};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dir_d    = dir_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (sync) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (shift_en) begin
      shift_d = shifted;
      dir_d   = eff_dir;
      case (state_q)
        IDLE: begin
          cnt_d   = CW'(1);
          state_d = RECV;
        end
        RECV: begin
          if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A word overwritten while still unread is an overrun; it beats clear_ovr.
    if (complete) begin
      data_d  = shifted;
      valid_d = 1'b1;
      if (valid_q && !data_ready) ovr_d = 1'b1;
      else if (clear_ovr)         ovr_d = 1'b0;
    end else begin
      if (valid_q && data_ready) valid_d = 1'b0;
      if (clear_ovr)             ovr_d   = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == RECV);

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - randomized self-checking bench for shift_deserializer
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rest_n;
  logic         serial_in, shift_en, shifter, sync, data_ready, clear_ovr;
  logic [W-1:0] data_out;
  logic         data_valid, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bits of the current word, plus handshake state.
  int           bq[$];
  bit           m_dir;
  logic [W-1:0] m_data;
  bit           m_valid, m_ovr;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rest_n(rest_n), .serial_in(serial_in), .shift_en(shift_en),
    .shifter(shifter), .sync(sync), .data_ready(data_ready), .clear_ovr(clear_ovr),
    .data_out(data_out), .data_valid(data_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    bq.delete();
    m_dir = 0; m_data = '0; m_valid = 0; m_ovr = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the rising edge, return at negedge.
  task automatic step(input bit sin, input bit en, input bit shf, input bit syn,
                      input bit rdy, input bit clr);
    logic [W-1:0] word;
    bit comp;
    serial_in = sin; shift_en = en; shifter = shf; sync = syn;
    data_ready = rdy; clear_ovr = clr;
    @(posedge clk);
    comp = 0; word = '0;
    if (syn) bq.delete();
    else if (en) begin
      if (bq.size() == 0) m_dir = shf;
      bq.push_back(int'(sin));
      if (bq.size() == W) begin
        for (int i = 0; i < W; i++)
          if (bq[i] != 0) word = word | (W'(1) << (m_dir ? i : W - 1 - i));
        comp = 1;
        bq.delete();
      end
    end
    if (comp) begin
      if (m_valid && !rdy) m_ovr = 1;
      else if (clr) m_ovr = 0;
      m_data = word; m_valid = 1;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (clr) m_ovr = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle(input bit rdy);
    step(0, 0, 0, 0, rdy, 0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit lsb, input bit rdy_last);
    for (int i = 0; i < W; i++)
      step(lsb ? w[i] : w[W-1-i], 1, lsb, 0, (i == W - 1) ? rdy_last : 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rest_n = 1'b1;
  endtask

  task automatic test_reset();
    serial_in = 0; shift_en = 0; shifter = 0; sync = 0; data_ready = 0; clear_ovr = 0;
    rest_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({data_out, data_valid, overrun, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", data_out, data_valid, overrun, busy);
    end
    @(negedge clk); rest_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy: got %b want 1", busy); end
    rest_n = 1'b0; #2;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    model_reset();
    @(negedge clk); rest_n = 1'b1;
    send_word(8'h96, 0, 0);
    n_checks++;
    if (data_out !== 8'h96 || data_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_word: got %h/%b want 96/1", data_out, data_valid);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    for (int i = 0; i < W; i++) step((i < 4) ? 1'b1 : 1'b0, 1, 0, 0, 0, 0);
    n_checks++;
    if (data_out !== 8'hF0 || data_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL msb_first: got %h/%b/%b want f0/1/0", data_out, data_valid, busy);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] pat;
    do_reset();
    pat = 8'b10100101;
    for (int i = 0; i < W; i++) step(pat[W-1-i], 1, 1, 0, (i == 0), 0);
    n_checks++;
    if (data_out !== 8'hA5) begin n_fail++; $display("FAIL lsb_first: got %h want a5", data_out); end
    idle_cycle(1);
    for (int i = 0; i < W; i++) step(pat[W-1-i], 1, (i == 0), 0, 0, 0);
    n_checks++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
      n_fail++; $display("FAIL lsb_toggle_shifter: got %h/%b want a5/1", data_out, data_valid);
    end
  endtask

  task automatic test_gap();
    logic [W-1:0] w;
    bit gap_ok;
    do_reset();
    w = 8'h3C; gap_ok = 1;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], 1, 0, 0, 0, 0);
      if (i == 3) for (int g = 0; g < 3; g++) begin
        step(~w[W-1-i], 0, 1, 0, 0, 0);
        if (busy !== 1'b1) gap_ok = 0;
      end
    end
    n_checks++;
    if (!gap_ok) begin n_fail++; $display("FAIL gap_busy: busy dropped during gap, want 1"); end
    n_checks++;
    if (data_out !== 8'h3C) begin n_fail++; $display("FAIL gap_word: got %h want 3c", data_out); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 0);
    n_checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: got %h/%b/%b want 22/1/1", data_out, data_valid, overrun);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    idle_cycle(1);
    n_checks++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL consume: got %b want 0", data_valid); end
    // Overrun on the same edge as clear_ovr must win.
    send_word(8'h33, 0, 0);
    for (int i = 0; i < W; i++) step(1'b1, 1, 0, 0, 0, (i == W - 1));
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_vs_clear: got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(8'h5A, 0, 0);
    send_word(8'hC6, 1, 1);
    n_checks++;
    if (data_out !== 8'hC6 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back: got %h/%b/%b want c6/1/0", data_out, data_valid, overrun);
    end
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || data_out !== 8'hC6 || data_valid !== 1'b1) begin
      n_fail++; $display("FAIL sync_realign: got busy=%b %h/%b want 0 c6/1", busy, data_out, data_valid);
    end
    send_word(8'h81, 0, 1);
    n_checks++;
    if (data_out !== 8'h81 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL sync_next_word: got %h/%b want 81/0", data_out, overrun);
    end
  endtask

  task automatic test_random();
    int errs;
    bit en, syn;
    do_reset();
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      syn = ($urandom_range(0, 40) == 0);
      step($urandom_range(0, 1), en, $urandom_range(0, 1), syn,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      n_checks++;
      if (data_out !== m_data || data_valid !== m_valid || overrun !== m_ovr ||
          busy !== (bq.size() != 0)) begin
        n_fail++;
        if (errs < 5)
          $display("FAIL random_cycle_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                   data_out, data_valid, overrun, busy, m_data, m_valid, m_ovr, bq.size() != 0);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gap();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
